// File: rtl/axi4_lite_regs.sv
// AXI4-Lite responder with three read/write registers and one read-only status word.
// AW and W are buffered independently; a write commits once both have arrived.
module axi4_lite_regs #(
    parameter logic [31:0] RST0 = 32'h0,
    parameter logic [31:0] RST1 = 32'h0,
    parameter logic [31:0] RST2 = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  awaddr,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] status,
    output logic [31:0] reg0,
    output logic [31:0] reg1,
    output logic [31:0] reg2,
    output logic [2:0]  wr_pulse
);

    logic        aw_full_q;
    logic [1:0]  aw_word_q;
    logic        w_full_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] reg0_q, reg1_q, reg2_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [2:0]  wr_pulse_q;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [1:0]  wr_word, rd_word;
    logic [31:0] wr_data, byte_mask, old_value, merged, rd_value;
    logic [3:0]  wr_strb;
    logic [2:0]  wr_sel;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

    assign awready  = !aw_full_q && !bvalid_q;
    assign wready   = !w_full_q && !bvalid_q;
    assign arready  = !rvalid_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = 2'b00;
    assign reg0     = reg0_q;
    assign reg1     = reg1_q;
    assign reg2     = reg2_q;
    assign wr_pulse = wr_pulse_q;

    always_comb begin
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        ar_hs   = arvalid && arready;
        // A beat accepted this cycle counts as present, so same-cycle AW+W commits at once.
        commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
        wr_word = aw_hs ? awaddr[3:2] : aw_word_q;
        wr_data = w_hs ? wdata : w_data_q;
        wr_strb = w_hs ? wstrb : w_strb_q;
        byte_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

        old_value = 32'h0;
        case (wr_word)
            2'd0:    old_value = reg0_q;
            2'd1:    old_value = reg1_q;
            2'd2:    old_value = reg2_q;
            default: old_value = 32'h0;
        endcase
        merged = (old_value & ~byte_mask) | (wr_data & byte_mask);

        wr_sel = 3'b000;
        if (commit && wr_word != 2'd3) begin
            wr_sel = 3'b001 << wr_word;
        end

        rd_word  = araddr[3:2];
        rd_value = 32'h0;
        case (rd_word)
            2'd0:    rd_value = reg0_q;
            2'd1:    rd_value = reg1_q;
            2'd2:    rd_value = reg2_q;
            default: rd_value = status;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            aw_full_q  <= 1'b0;
            aw_word_q  <= 2'd0;
            w_full_q   <= 1'b0;
            w_data_q   <= 32'h0;
            w_strb_q   <= 4'h0;
            reg0_q     <= RST0;
            reg1_q     <= RST1;
            reg2_q     <= RST2;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            wr_pulse_q <= 3'b000;
        end else begin
            if (commit) begin
                aw_full_q <= 1'b0;
            end else if (aw_hs) begin
                aw_full_q <= 1'b1;
            end
            if (aw_hs) begin
                aw_word_q <= awaddr[3:2];
            end

            if (commit) begin
                w_full_q <= 1'b0;
            end else if (w_hs) begin
                w_full_q <= 1'b1;
            end
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end

            if (wr_sel[0]) reg0_q <= merged;
            if (wr_sel[1]) reg1_q <= merged;
            if (wr_sel[2]) reg2_q <= merged;
            wr_pulse_q <= (|wr_strb) ? wr_sel : 3'b000;

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (wr_word == 2'd3) ? 2'b10 : 2'b00;
            end else if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
            end

            // Nonblocking reg updates mean a same-cycle read sees the pre-write value.
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_value;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_regs.sv
// Directed bench for axi4_lite_regs: write buffering, strobes, SLVERR, read hold,
// read/write collision and mid-transaction reset.
module tb_axi4_lite_regs;

    localparam logic [31:0] R0 = 32'h0000_0000;
    localparam logic [31:0] R1 = 32'h1234_5678;
    localparam logic [31:0] R2 = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] status;
    logic [31:0] reg0, reg1, reg2;
    logic [2:0]  wr_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4_lite_regs #(
        .RST0(R0),
        .RST1(R1),
        .RST2(R2)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .status(status),
        .reg0(reg0), .reg1(reg1), .reg2(reg2),
        .wr_pulse(wr_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e0, e1, e2);
        check({tag, ".reg0"}, reg0, e0);
        check({tag, ".reg1"}, reg1, e1);
        check({tag, ".reg2"}, reg2, e2);
    endtask

    initial begin
        rst = 1'b0; awaddr = 4'h0; awprot = 3'h0; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 4'h0; arprot = 3'h0; arvalid = 1'b0; rready = 1'b0; status = 32'h0;
        tick(); tick();
        rst = 1'b1;

        // Reset state
        check_regs("rst", R0, R1, R2);
        check("rst.bvalid", {31'b0, bvalid}, 32'd0);
        check("rst.rvalid", {31'b0, rvalid}, 32'd0);
        check("rst.awready", {31'b0, awready}, 32'd1);
        check("rst.wready", {31'b0, wready}, 32'd1);
        check("rst.arready", {31'b0, arready}, 32'd1);
        check("rst.wr_pulse", {29'b0, wr_pulse}, 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.bresp", {30'b0, bresp}, 32'd0);
        check("rst.rresp", {30'b0, rresp}, 32'd0);

        // Same-cycle AW+W to word 1
        awvalid = 1'b1; awaddr = 4'h4; wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("w1.bvalid", {31'b0, bvalid}, 32'd1);
        check("w1.bresp", {30'b0, bresp}, 32'd0);
        check("w1.reg1", reg1, 32'hDEAD_BEEF);
        check("w1.pulse", {29'b0, wr_pulse}, 32'd2);
        check("w1.awready", {31'b0, awready}, 32'd0);
        tick();
        check("w1.pulse_gone", {29'b0, wr_pulse}, 32'd0);
        check("w1.bvalid_hold", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("w1.bvalid_clr", {31'b0, bvalid}, 32'd0);
        check("w1.awready_back", {31'b0, awready}, 32'd1);

        // W leads AW by three cycles, partial strobes on word 2
        wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'b0101;
        tick();
        wvalid = 1'b0;
        check("w2.wready_buf", {31'b0, wready}, 32'd0);
        check("w2.awready_wait", {31'b0, awready}, 32'd1);
        check("w2.no_bvalid", {31'b0, bvalid}, 32'd0);
        tick();
        check("w2.reg2_unchanged", reg2, R2);
        tick();
        awvalid = 1'b1; awaddr = 4'h8;
        tick();
        awvalid = 1'b0;
        check("w2.bvalid", {31'b0, bvalid}, 32'd1);
        check("w2.reg2", reg2, 32'hFF22_FF44);
        check("w2.pulse", {29'b0, wr_pulse}, 32'd4);
        for (int i = 0; i < 2; i++) begin
            check("w2.awready_low", {31'b0, awready}, 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("w2.awready_after", {31'b0, awready}, 32'd1);
        check("w2.wready_after", {31'b0, wready}, 32'd1);

        // Write to read-only word 3
        awvalid = 1'b1; awaddr = 4'hC; wvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("w3.bvalid", {31'b0, bvalid}, 32'd1);
        check("w3.bresp", {30'b0, bresp}, 32'd2);
        check("w3.pulse", {29'b0, wr_pulse}, 32'd0);
        check_regs("w3", R0, 32'hDEAD_BEEF, 32'hFF22_FF44);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Status read held while rready is low
        status = 32'hCAFE_0001; arvalid = 1'b1; araddr = 4'hC;
        tick();
        arvalid = 1'b0;
        check("r3.rvalid", {31'b0, rvalid}, 32'd1);
        check("r3.rdata", rdata, 32'hCAFE_0001);
        for (int i = 0; i < 4; i++) begin
            status = 32'h0BAD_0000 + 32'(i);
            tick();
            check("r3.rdata_hold", rdata, 32'hCAFE_0001);
            check("r3.arready_low", {31'b0, arready}, 32'd0);
            check("r3.rresp", {30'b0, rresp}, 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r3.rvalid_clr", {31'b0, rvalid}, 32'd0);
        check("r3.arready_back", {31'b0, arready}, 32'd1);

        // Read and write of word 0 in the same cycle
        awvalid = 1'b1; awaddr = 4'h0; wvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 4'h0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw.rdata_old", rdata, 32'h0);
        check("rw.reg0", reg0, 32'h5);
        check("rw.pulse", {29'b0, wr_pulse}, 32'd1);
        check("rw.bvalid", {31'b0, bvalid}, 32'd1);
        check("rw.rvalid", {31'b0, rvalid}, 32'd1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;

        // Reset with a pending write response
        awvalid = 1'b1; awaddr = 4'h4; wvalid = 1'b1; wdata = 32'h0000_00AB; wstrb = 4'h1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("rs1.bvalid_pre", {31'b0, bvalid}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rs1.bvalid", {31'b0, bvalid}, 32'd0);
        check("rs1.awready", {31'b0, awready}, 32'd1);
        check("rs1.wready", {31'b0, wready}, 32'd1);
        check_regs("rs1", R0, R1, R2);

        // Reset with a buffered W beat and a pending read response
        wvalid = 1'b1; wdata = 32'hAAAA_AAAA; wstrb = 4'hF; arvalid = 1'b1; araddr = 4'h4;
        tick();
        wvalid = 1'b0; arvalid = 1'b0;
        check("rs2.wready_buf", {31'b0, wready}, 32'd0);
        check("rs2.rvalid_pre", {31'b0, rvalid}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rs2.wready", {31'b0, wready}, 32'd1);
        check("rs2.rvalid", {31'b0, rvalid}, 32'd0);
        check("rs2.rdata", rdata, 32'h0);
        // A lone AW afterwards must wait: the pre-reset W beat is gone
        awvalid = 1'b1; awaddr = 4'h0;
        tick();
        awvalid = 1'b0;
        check("rs2.no_commit", {31'b0, bvalid}, 32'd0);
        check("rs2.aw_buffered", {31'b0, awready}, 32'd0);
        check("rs2.reg0", reg0, R0);
        wvalid = 1'b1; wdata = 32'h0000_0007; wstrb = 4'h1;
        tick();
        wvalid = 1'b0;
        check("rs2.bvalid", {31'b0, bvalid}, 32'd1);
        check("rs2.reg0_new", reg0, 32'h7);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_regs.md
AXI4_LITE_REGS -- requirements
Module: axi4_lite_regs

Interface
REQ-001 The block SHALL be parameterised as follows:
- RST0, 32'h0, reset value of reg 0.
- RST1, 32'h0, reset value of reg 1.
- RST2, 32'h0, reset value of reg 2.

REQ-002 The clock SHALL be `clk`, one clock domain; the reset SHALL be `rst`, synchronous, active-low.

REQ-003 The ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- awaddr  in  4  write byte address
- awprot  in  3  ignored
- awvalid  in  1
- awready  out  1
- wdata  in  32
- wstrb  in  4  byte enables
- wvalid  in  1
- wready  out  1
- bresp  out  2
- bvalid  out  1
- bready  in  1
- araddr  in  4  read byte address
- arprot  in  3  ignored
- arvalid  in  1
- arready  out  1
- rdata  out  32
- rresp  out  2
- rvalid  out  1
- rready  in  1
- status  in  32  read-only value for reg 3
- reg0, reg1, reg2  out  32 each  register contents
- wr_pulse  out  3  one-cycle strobe per written reg

Function
REQ-004 The block SHALL be an AXI4-Lite responder (slave) with four 32-bit words, selected by addr[3:2]; addr[1:0] SHALL be ignored.

REQ-005 awready SHALL be 1 iff no write address is buffered and bvalid=0; wready SHALL be 1 iff no write data is buffered and bvalid=0.

REQ-006 AW and W SHALL be accepted independently, in either order or in the same cycle; each accepted beat SHALL be held in a one-entry buffer until its partner arrives.

REQ-007 Commit SHALL occur in the cycle in which both buffers are full (buffered or accepted that cycle). For each byte with wstrb[i]=1, the target register byte SHALL take wdata[8i+7:8i] on the next edge.

REQ-008 A write to word 3 SHALL not modify any state and SHALL return bresp=2'b10 (SLVERR); writes to words 0-2 SHALL return bresp=2'b00.

REQ-009 bvalid SHALL rise on the edge after commit and SHALL hold, with bresp stable, until bvalid&&bready; both buffers SHALL clear at commit.

REQ-010 wr_pulse[n] SHALL be 1 for exactly the one cycle in which the new regn value first appears on its output, and only if at least one strobe bit was set.

REQ-011 arready SHALL equal !rvalid.

REQ-012 On arvalid&&arready, rvalid SHALL be 1 on the next edge, with rdata taken from the addressed word (word 3: status sampled in the accept cycle) and rresp=2'b00.

REQ-013 rdata, rresp and rvalid SHALL hold until rvalid&&rready.

REQ-014 A read accepted in the same cycle as a commit to the same word SHALL return the pre-write value.

REQ-015 Read and write channels SHALL operate concurrently without mutual stalls.

REQ-016 Valid-before-ready SHALL be tolerated indefinitely; back-to-back transactions SHALL sustain one write per 2 cycles and one read per 2 cycles when bready and rready are held at 1.

Reset
REQ-017 While rst=0, the block SHALL be in the following state, taking effect on the next edge:
- reg0..reg2 = RST0..RST2
- bvalid=0, rvalid=0
- awready=1, wready=1, arready=1
- buffers empty
- wr_pulse=0
- rdata=0, bresp=0, rresp=0

REQ-018 A reset asserted mid-transaction SHALL discard buffered AW/W and any pending B/R responses without committing.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- AW=0x4 and W=0xDEADBEEF, wstrb=4'hF in the same cycle -> bvalid=1 with bresp=0 the next cycle; reg1=0xDEADBEEF; wr_pulse=3'b010 for exactly one cycle.
- W=0x11223344 with wstrb=4'b0101 sent 3 cycles before AW=0x8, reg2 previously 0xFFFFFFFF -> reg2=0xFF22FF44; awready low until bvalid&&bready.
- Write to 0xC -> bresp=2'b10; reg0..reg2 and wr_pulse unchanged.
- status=0xCAFE0001, read 0xC with rready=0 for 4 cycles while status changes -> rdata stays 0xCAFE0001 and arready=0 until handshake.
- Read 0x0 accepted in the same cycle as the write 0x0 commit of 0x5 (reg0 was 0x0) -> rdata=0x0; reg0=0x5 afterwards.
- rst=0 while bvalid=1 and a W beat is buffered -> bvalid=0 and awready=wready=1 next cycle; reg values equal RST0..RST2.
